// File: rtl/mure_block_packer_if.sv
// Bundle between the uop/common FIFOs, the block packer and the trace
// encoder ingress.
//   uop_*    : uop FIFO pop side   (valid = not empty, ready = pop strobe)
//   common_* : common FIFO pop side (cause/tval/priv for trap blocks)
//   flush_i  : force close of the open block
//   valid_o/ready_i + block fields : closed block towards the encoder
// master = FIFO/encoder environment, slave = block packer.
interface mure_block_packer_if #(
    parameter int IRETIRE_LEN = 8,
    parameter int XLEN        = 32,
    parameter int CAUSE_LEN   = 5,
    parameter int PRIV_LEN    = 2
);
    logic                              uop_valid_i;
    logic [37:0]                       uop_entry_i;
    logic                              uop_ready_o;
    logic                              common_valid_i;
    logic [CAUSE_LEN+XLEN+PRIV_LEN-1:0] common_entry_i;
    logic                              common_ready_o;
    logic                              flush_i;
    logic                              valid_o;
    logic                              ready_i;
    logic [2:0]                        itype_o;
    logic [31:0]                       iaddr_o;
    logic [IRETIRE_LEN-1:0]            iretire_o;
    logic [1:0]                        ilastsize_o;
    logic [CAUSE_LEN-1:0]              cause_o;
    logic [XLEN-1:0]                   tval_o;
    logic [PRIV_LEN-1:0]               priv_o;

    modport master (
        output uop_valid_i, uop_entry_i, common_valid_i, common_entry_i, flush_i, ready_i,
        input  uop_ready_o, common_ready_o, valid_o, itype_o, iaddr_o, iretire_o,
               ilastsize_o, cause_o, tval_o, priv_o
    );
    modport slave (
        input  uop_valid_i, uop_entry_i, common_valid_i, common_entry_i, flush_i, ready_i,
        output uop_ready_o, common_ready_o, valid_o, itype_o, iaddr_o, iretire_o,
               ilastsize_o, cause_o, tval_o, priv_o
    );
endinterface

// File: rtl/mure_block_packer.sv
// Trace block packer. Pops uop entries, packs consecutive STD/RES
// retirements into one block and closes it on a control-flow itype, on
// retirement-counter saturation or on flush. Trap blocks (EXC/INT) take
// cause/tval/priv from the common FIFO before being emitted.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : uop/common FIFO pop ports, flush, block output port
module mure_block_packer #(
    parameter int                  IRETIRE_LEN = 8,
    parameter int                  XLEN        = 32,
    parameter int                  CAUSE_LEN   = 5,
    parameter int                  PRIV_LEN    = 2,
    parameter logic [PRIV_LEN-1:0] PRIV_RESET  = 2'b11
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mure_block_packer_if.slave  bus
);
    typedef enum logic [2:0] {
        IT_STD = 3'd0, IT_EXC = 3'd1, IT_INT = 3'd2, IT_ERET = 3'd3,
        IT_NTB = 3'd4, IT_TB  = 3'd5, IT_UIJ = 3'd6, IT_RES  = 3'd7
    } itype_e;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WAIT, S_EMIT} state_e;

    localparam logic [IRETIRE_LEN:0] CNT_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};

    state_e                 r_state, w_state_n;
    logic [31:0]            r_iaddr, w_iaddr_n;
    logic [IRETIRE_LEN-1:0] r_cnt, w_cnt_n;
    logic [1:0]             r_last, w_last_n;
    itype_e                 r_trap_itype;
    logic [PRIV_LEN-1:0]    r_priv;

    logic                   r_valid;
    itype_e                 r_itype_o;
    logic [31:0]            r_iaddr_o;
    logic [IRETIRE_LEN-1:0] r_iret_o;
    logic [1:0]             r_last_o;
    logic [CAUSE_LEN-1:0]   r_cause_o;
    logic [XLEN-1:0]        r_tval_o;
    logic [PRIV_LEN-1:0]    r_priv_o;

    // Incoming uop entry fields
    itype_e                 w_e_itype;
    logic [31:0]            w_e_iaddr;
    logic                   w_e_iret;
    logic [1:0]             w_e_last;
    logic [IRETIRE_LEN:0]   w_inc, w_sum;
    logic                   w_ovf, w_pop, w_cpop, w_close;
    itype_e                 w_close_itype;

    assign w_e_itype = itype_e'(bus.uop_entry_i[37:35]);
    assign w_e_iaddr = bus.uop_entry_i[34:3];
    assign w_e_iret  = bus.uop_entry_i[2];
    assign w_e_last  = bus.uop_entry_i[1:0];

    // Halfwords retired by this entry: 2B -> 1, 4B -> 2
    assign w_inc = !w_e_iret ? '0 :
                   (w_e_last == 2'd1) ? (IRETIRE_LEN+1)'(2) : (IRETIRE_LEN+1)'(1);
    assign w_sum = {1'b0, r_cnt} + w_inc;
    // Saturation check only matters with an open block; an entry that would
    // overflow is left in the FIFO to start the next block.
    assign w_ovf = (r_state == S_ACCUM) && bus.uop_valid_i && (w_sum > CNT_MAX);

    always_comb begin
        w_state_n     = r_state;
        w_pop         = 1'b0;
        w_cpop        = 1'b0;
        w_close       = 1'b0;
        w_close_itype = IT_STD;
        unique case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_ovf) begin
                    w_close   = 1'b1;
                    w_state_n = S_EMIT;
                end else if (bus.uop_valid_i) begin
                    w_pop = 1'b1;
                    unique case (w_e_itype)
                        IT_STD, IT_RES: w_state_n = S_ACCUM;
                        IT_EXC, IT_INT: w_state_n = S_WAIT;
                        default: begin
                            w_close       = 1'b1;
                            w_close_itype = w_e_itype;
                            w_state_n     = S_EMIT;
                        end
                    endcase
                end else if (r_state == S_ACCUM && bus.flush_i) begin
                    w_close   = 1'b1;
                    w_state_n = S_EMIT;
                end
            end
            S_WAIT: begin
                if (bus.common_valid_i) begin
                    w_cpop    = 1'b1;
                    w_state_n = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.ready_i) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase

        // Accumulator next values; the closing pop folds into the block
        // emitted on the same edge.
        w_iaddr_n = r_iaddr;
        w_cnt_n   = r_cnt;
        w_last_n  = r_last;
        if (w_pop) begin
            if (r_state == S_IDLE) begin
                w_iaddr_n = w_e_iaddr;
                w_cnt_n   = w_inc[IRETIRE_LEN-1:0];
                w_last_n  = w_e_iret ? w_e_last : 2'd0;
            end else begin
                w_cnt_n = w_sum[IRETIRE_LEN-1:0];
                if (w_e_iret) w_last_n = w_e_last;
            end
        end else if (r_state == S_EMIT && bus.ready_i) begin
            w_cnt_n = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_iaddr      <= '0;
            r_cnt        <= '0;
            r_last       <= '0;
            r_trap_itype <= IT_STD;
            r_priv       <= PRIV_RESET;
            r_valid      <= 1'b0;
            r_itype_o    <= IT_STD;
            r_iaddr_o    <= '0;
            r_iret_o     <= '0;
            r_last_o     <= '0;
            r_cause_o    <= '0;
            r_tval_o     <= '0;
            r_priv_o     <= '0;
        end else begin
            r_state <= w_state_n;
            r_iaddr <= w_iaddr_n;
            r_cnt   <= w_cnt_n;
            r_last  <= w_last_n;
            if (w_pop) r_trap_itype <= w_e_itype;
            if (w_close) begin
                r_valid   <= 1'b1;
                r_itype_o <= w_close_itype;
                r_iaddr_o <= w_iaddr_n;
                r_iret_o  <= w_cnt_n;
                r_last_o  <= w_last_n;
                r_cause_o <= '0;
                r_tval_o  <= '0;
                r_priv_o  <= r_priv;
            end else if (w_cpop) begin
                r_valid   <= 1'b1;
                r_itype_o <= r_trap_itype;
                r_iaddr_o <= r_iaddr;
                r_iret_o  <= r_cnt;
                r_last_o  <= r_last;
                r_cause_o <= bus.common_entry_i[CAUSE_LEN+XLEN+PRIV_LEN-1 -: CAUSE_LEN];
                r_tval_o  <= bus.common_entry_i[XLEN+PRIV_LEN-1 -: XLEN];
                r_priv_o  <= bus.common_entry_i[PRIV_LEN-1:0];
                r_priv    <= bus.common_entry_i[PRIV_LEN-1:0];
            end else if (r_valid && bus.ready_i) begin
                r_valid   <= 1'b0;
                r_itype_o <= IT_STD;
                r_iaddr_o <= '0;
                r_iret_o  <= '0;
                r_last_o  <= '0;
                r_cause_o <= '0;
                r_tval_o  <= '0;
                r_priv_o  <= '0;
            end
        end
    end

    assign bus.uop_ready_o    = w_pop;
    assign bus.common_ready_o = w_cpop;
    assign bus.valid_o        = r_valid;
    assign bus.itype_o        = r_itype_o;
    assign bus.iaddr_o        = r_iaddr_o;
    assign bus.iretire_o      = r_iret_o;
    assign bus.ilastsize_o    = r_last_o;
    assign bus.cause_o        = r_cause_o;
    assign bus.tval_o         = r_tval_o;
    assign bus.priv_o         = r_priv_o;
endmodule

// File: tb/tb_mure_block_packer.sv
module tb_mure_block_packer;
    localparam logic [2:0] STD = 3'd0, EXC = 3'd1, INT = 3'd2, ERET = 3'd3,
                           NTB = 3'd4, TB = 3'd5, UIJ = 3'd6, RES = 3'd7;
    localparam int MAXCNT = 255;

    typedef struct packed {
        logic [2:0]  it;
        logic [31:0] a;
        logic [7:0]  r;
        logic [1:0]  l;
        logic [4:0]  c;
        logic [31:0] t;
        logic [1:0]  p;
    } blk_t;

    typedef struct {
        logic [2:0]  it;
        logic [31:0] a;
        logic        r;
        logic [1:0]  l;
    } ent_t;

    typedef struct {
        logic [2:0]  it;
        logic [31:0] a;
        logic        r;
        logic [1:0]  l;
        logic [4:0]  c;
        logic [31:0] t;
        logic [1:0]  p;
        blk_t        e;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    mure_block_packer_if #(.IRETIRE_LEN(8), .XLEN(32), .CAUSE_LEN(5), .PRIV_LEN(2)) bus();
    mure_block_packer #(.IRETIRE_LEN(8), .XLEN(32), .CAUSE_LEN(5), .PRIV_LEN(2), .PRIV_RESET(2'b11))
        dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));

    int   n_chk = 0, n_pass = 0;
    blk_t got[$], exp_q[$];
    ent_t ents[$];
    logic [38:0] commons[$];
    bit   hold = 0;
    blk_t held;
    bit   udone, cdone;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic blk_t cur();
        return {bus.itype_o, bus.iaddr_o, bus.iretire_o, bus.ilastsize_o,
                bus.cause_o, bus.tval_o, bus.priv_o};
    endfunction

    function automatic blk_t mk(input logic [2:0] it, input logic [31:0] a, input logic [7:0] r,
                                input logic [1:0] l, input logic [4:0] c, input logic [31:0] t,
                                input logic [1:0] p);
        return {it, a, r, l, c, t, p};
    endfunction

    function automatic logic [37:0] ue(input logic [2:0] it, input logic [31:0] a,
                                       input logic r, input logic [1:0] l);
        return {it, a, r, l};
    endfunction

    task automatic nxt(); @(posedge clk_i); #1; endtask
    task automatic smp(); @(negedge clk_i); endtask

    // Present one uop entry until it is popped; returns just after the pop edge.
    task automatic push(input logic [37:0] e);
        int n = 0;
        bus.uop_valid_i = 1'b1;
        bus.uop_entry_i = e;
        smp();
        while (!bus.uop_ready_o && n < 300) begin smp(); n++; end
        if (n >= 300) chk("push_wait", bus.uop_ready_o, 1);
        nxt();
        bus.uop_valid_i = 1'b0;
    endtask

    // Collect accepted blocks; check outputs hold while stalled.
    always @(negedge clk_i) begin
        if (rst_i) hold = 0;
        else begin
            if (hold) chk("hold_stable", cur(), held);
            if (bus.valid_o && bus.ready_i) got.push_back(cur());
            hold = bus.valid_o && !bus.ready_i;
            held = cur();
        end
    end

    // Spec-level model: walk the entry list and cut blocks by the rules.
    task automatic model();
        int cnt = 0, inc, ci = 0;
        bit open = 0;
        blk_t b = '0;
        logic [1:0] priv = 2'b11;
        exp_q.delete();
        foreach (ents[i]) begin
            inc = ents[i].r ? ((ents[i].l == 2'd1) ? 2 : 1) : 0;
            if (open && cnt + inc > MAXCNT) begin
                b.r = cnt[7:0]; b.it = STD; b.p = priv;
                exp_q.push_back(b);
                open = 0;
            end
            if (!open) begin b = '0; b.a = ents[i].a; cnt = 0; open = 1; end
            cnt += inc;
            if (ents[i].r) b.l = ents[i].l;
            if (ents[i].it != STD && ents[i].it != RES) begin
                b.r = cnt[7:0]; b.it = ents[i].it;
                if (ents[i].it == EXC || ents[i].it == INT) begin
                    {b.c, b.t, b.p} = commons[ci];
                    priv = commons[ci][1:0];
                    ci++;
                end else b.p = priv;
                exp_q.push_back(b);
                open = 0;
            end
        end
        if (open) begin b.r = cnt[7:0]; b.it = STD; b.p = priv; exp_q.push_back(b); end
    endtask

    vec_t vecs[8];
    int g;

    initial begin
        vecs[0] = '{NTB,  32'h1000, 1, 1, 0, 0, 0, mk(NTB,  32'h1000, 2, 1, 0, 0, 1)};
        vecs[1] = '{TB,   32'h1002, 1, 0, 0, 0, 0, mk(TB,   32'h1002, 1, 0, 0, 0, 1)};
        vecs[2] = '{ERET, 32'h2000, 0, 1, 0, 0, 0, mk(ERET, 32'h2000, 0, 0, 0, 0, 1)};
        vecs[3] = '{UIJ,  32'h3000, 1, 1, 0, 0, 0, mk(UIJ,  32'h3000, 2, 1, 0, 0, 1)};
        vecs[4] = '{INT,  32'h4000, 1, 1, 7, 32'h12345678, 0, mk(INT, 32'h4000, 2, 1, 7, 32'h12345678, 0)};
        vecs[5] = '{EXC,  32'h5000, 0, 0, 3, 32'hCAFE, 3, mk(EXC, 32'h5000, 0, 0, 3, 32'hCAFE, 3)};
        vecs[6] = '{NTB,  32'h6000, 1, 0, 0, 0, 0, mk(NTB,  32'h6000, 1, 0, 0, 0, 3)};
        vecs[7] = '{INT,  32'h7000, 1, 0, 5, 32'hABCD, 1, mk(INT, 32'h7000, 1, 0, 5, 32'hABCD, 1)};

        rst_i = 1'b1;
        bus.uop_valid_i = 0; bus.uop_entry_i = '0; bus.common_valid_i = 0;
        bus.common_entry_i = '0; bus.flush_i = 0; bus.ready_i = 0;
        smp();
        chk("rst_outputs", {bus.valid_o, cur(), bus.uop_ready_o, bus.common_ready_o}, '0);
        nxt(); rst_i = 1'b0;

        // STD x3 then TB -> one TB block, valid the cycle after the TB pop
        bus.ready_i = 1;
        push(ue(STD, 32'h100, 1, 1)); push(ue(STD, 32'h104, 1, 1));
        push(ue(STD, 32'h108, 1, 1)); push(ue(TB, 32'h10C, 1, 1));
        smp();
        chk("A_valid", bus.valid_o, 1);
        chk("A_blk", cur(), mk(TB, 32'h100, 8, 1, 0, 0, 3));
        nxt(); smp();
        chk("A_drop", bus.valid_o, 0);
        nxt();

        // Backpressure: 5 stalled cycles, no pops, stable outputs
        bus.ready_i = 0;
        push(ue(NTB, 32'h500, 1, 1));
        bus.uop_valid_i = 1; bus.uop_entry_i = ue(STD, 32'h600, 1, 1);
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("D_valid", bus.valid_o, 1);
            chk("D_no_pop", bus.uop_ready_o, 0);
            chk("D_blk", cur(), mk(NTB, 32'h500, 2, 1, 0, 0, 3));
            nxt();
        end
        bus.ready_i = 1; bus.uop_valid_i = 0;
        smp(); chk("D_valid6", bus.valid_o, 1);
        nxt(); smp();
        chk("D_idle", {bus.valid_o, bus.iretire_o}, 0);
        nxt();

        // Flush closes an open STD block; flush in IDLE does nothing
        push(ue(STD, 32'h300, 1, 1)); push(ue(STD, 32'h304, 1, 1));
        bus.flush_i = 1; nxt(); bus.flush_i = 0;
        smp();
        chk("E_blk", {bus.valid_o, cur()}, {1'b1, mk(STD, 32'h300, 4, 1, 0, 0, 3)});
        nxt();
        g = got.size();
        bus.flush_i = 1;
        for (int k = 0; k < 3; k++) begin smp(); chk("E_idle_flush", bus.valid_o, 0); nxt(); end
        bus.flush_i = 0;
        chk("E_no_block", got.size(), g);

        // Counter saturation: 127 x 4B fill 254, the 128th cannot fit
        got.delete();
        for (int i = 0; i < 127; i++) push(ue(STD, 32'(i * 4), 1, 1));
        bus.uop_valid_i = 1; bus.uop_entry_i = ue(STD, 32'h1FC, 1, 1);
        smp(); chk("C_ovf_no_pop", bus.uop_ready_o, 0);
        nxt(); smp(); chk("C_ovf_valid", bus.valid_o, 1);
        nxt();
        push(ue(STD, 32'h1FC, 1, 1)); push(ue(STD, 32'h200, 1, 1)); push(ue(STD, 32'h204, 1, 1));
        bus.flush_i = 1; nxt(); bus.flush_i = 0; nxt(); nxt();
        chk("C_nblk", got.size(), 2);
        if (got.size() == 2) begin
            chk("C_blk0", got[0], mk(STD, 32'h0, 254, 1, 0, 0, 3));
            chk("C_blk1", got[1], mk(STD, 32'h1FC, 6, 1, 0, 0, 3));
        end

        // Trap waits for the common FIFO, then priv carries forward
        push(ue(STD, 32'h200, 1, 0)); push(ue(EXC, 32'h202, 0, 0));
        for (int k = 0; k < 3; k++) begin
            smp(); chk("B_wait", {bus.valid_o, bus.common_ready_o}, 0); nxt();
        end
        bus.common_valid_i = 1; bus.common_entry_i = {5'd2, 32'hDEAD, 2'd1};
        smp(); chk("B_cpop", bus.common_ready_o, 1);
        nxt(); bus.common_valid_i = 0;
        smp(); chk("B_blk", {bus.valid_o, cur()}, {1'b1, mk(EXC, 32'h200, 1, 0, 2, 32'hDEAD, 1)});
        nxt();
        push(ue(STD, 32'h210, 1, 1));
        bus.flush_i = 1; nxt(); bus.flush_i = 0;
        smp(); chk("B_priv_next", {bus.valid_o, cur()}, {1'b1, mk(STD, 32'h210, 2, 1, 0, 0, 1)});
        nxt();

        // Single-entry blocks from IDLE, including trap latency N+2
        foreach (vecs[i]) begin
            if (vecs[i].it == EXC || vecs[i].it == INT) begin
                bus.common_valid_i = 1;
                bus.common_entry_i = {vecs[i].c, vecs[i].t, vecs[i].p};
            end
            push(ue(vecs[i].it, vecs[i].a, vecs[i].r, vecs[i].l));
            smp();
            if (vecs[i].it == EXC || vecs[i].it == INT) begin
                chk("T_trap_wait", {bus.valid_o, bus.common_ready_o}, 2'b01);
                nxt(); bus.common_valid_i = 0; smp();
            end
            chk("T_blk", {bus.valid_o, cur()}, {1'b1, vecs[i].e});
            nxt();
        end

        // Reset during EMIT drops the block and restores priv
        bus.ready_i = 0;
        push(ue(TB, 32'h800, 1, 1));
        smp(); chk("F_pre", {bus.valid_o, cur()}, {1'b1, mk(TB, 32'h800, 2, 1, 0, 0, 1)});
        nxt(); rst_i = 1; nxt(); rst_i = 0;
        smp(); chk("F_rst_outs", {bus.valid_o, cur()}, '0);
        nxt();
        g = got.size();
        bus.ready_i = 1;
        push(ue(TB, 32'h900, 1, 0));
        smp(); chk("F_priv_reset", cur(), mk(TB, 32'h900, 1, 0, 0, 0, 3));
        nxt();
        chk("F_nblk", got.size(), g + 1);

        // Randomized traffic against the model
        rst_i = 1; nxt(); nxt(); rst_i = 0;
        got.delete(); ents.delete(); commons.delete();
        for (int i = 0; i < 300; i++) begin
            ent_t e;
            int p = $urandom_range(0, 99);
            e.a = $urandom & 32'hFFFF_FFFE;
            if (i < 140) begin
                e.it = ($urandom_range(0, 9) == 0) ? RES : STD;
                e.r = 1; e.l = ($urandom_range(0, 7) != 0) ? 2'd1 : 2'd0;
            end else begin
                if (p < 35) e.it = 3'($urandom_range(1, 6));
                else e.it = ($urandom_range(0, 9) == 0) ? RES : STD;
                e.r = ($urandom_range(0, 9) != 0); e.l = 2'($urandom_range(0, 1));
            end
            if (e.it == EXC || e.it == INT)
                commons.push_back({5'($urandom), 32'($urandom), 2'($urandom_range(0, 3))});
            ents.push_back(e);
        end
        model();
        udone = 0; cdone = 0;
        fork
            begin
                foreach (ents[i]) begin
                    repeat ($urandom_range(0, 2)) nxt();
                    push(ue(ents[i].it, ents[i].a, ents[i].r, ents[i].l));
                end
                udone = 1;
            end
            begin
                foreach (commons[k]) begin
                    int n = 0;
                    repeat ($urandom_range(0, 3)) nxt();
                    bus.common_valid_i = 1; bus.common_entry_i = commons[k];
                    smp();
                    while (!bus.common_ready_o && n < 5000) begin smp(); n++; end
                    if (n >= 5000) chk("R_common_wait", bus.common_ready_o, 1);
                    nxt(); bus.common_valid_i = 0;
                end
                cdone = 1;
            end
            begin
                while (!(udone && cdone)) begin
                    bus.ready_i = ($urandom_range(0, 3) != 0);
                    nxt();
                end
                bus.ready_i = 1;
            end
        join
        bus.flush_i = 1;
        for (int n = 0; n < 500 && got.size() < exp_q.size(); n++) nxt();
        bus.flush_i = 0;
        nxt(); nxt();
        chk("R_nblk", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("R_blk", got[i], exp_q[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
